// File: rtl/cs_flow_if.sv
// Flag handshake bundle between cs_flow and the mac/fifoc/fifod/adc blocks.
// master = sequencer side, slave = the blocks it drives.
interface cs_flow_if #(
    parameter int OVR_W = 8
);
    logic             fs_adc;
    logic             fifoc_full;
    logic             fifod_full;
    logic             fs_udp_rx;
    logic             fd_udp_rx;
    logic             fs_mac2fifoc;
    logic             fd_mac2fifoc;
    logic             fs_fifoc2cs;
    logic             fd_fifoc2cs;
    logic             fs_adc_conf;
    logic             fd_adc_conf;
    logic             fs_adc_read;
    logic             fd_adc_read;
    logic             fs_adc_fifo;
    logic             fd_adc_fifo;
    logic             fs_fifod2mac;
    logic             fd_fifod2mac;
    logic             fs_udp_tx;
    logic             fd_udp_tx;
    logic [3:0]       state;
    logic             err;
    logic [OVR_W-1:0] ovr_cnt;

    modport master (
        input  fs_adc, fifoc_full, fifod_full, fs_udp_rx,
        input  fd_mac2fifoc, fd_fifoc2cs, fd_adc_conf,
        input  fd_adc_read, fd_adc_fifo, fd_fifod2mac, fd_udp_tx,
        output fd_udp_rx,
        output fs_mac2fifoc, fs_fifoc2cs, fs_adc_conf,
        output fs_adc_read, fs_adc_fifo, fs_fifod2mac, fs_udp_tx,
        output state, err, ovr_cnt
    );

    modport slave (
        output fs_adc, fifoc_full, fifod_full, fs_udp_rx,
        output fd_mac2fifoc, fd_fifoc2cs, fd_adc_conf,
        output fd_adc_read, fd_adc_fifo, fd_fifod2mac, fd_udp_tx,
        input  fd_udp_rx,
        input  fs_mac2fifoc, fs_fifoc2cs, fs_adc_conf,
        input  fs_adc_read, fs_adc_fifo, fs_fifod2mac, fs_udp_tx,
        input  state, err, ovr_cnt
    );
endinterface

// File: rtl/cs_flow.sv
// Control-section sequencer: command receive/parse/configure, then one
// read->fifo->mac->tx frame per sample tick, with stage timeouts and overrun count.
module cs_flow #(
    parameter logic [15:0] TIMEOUT = 16'd50000,
    parameter int          OVR_W   = 8
) (
    input  logic      clk,
    input  logic      rst,
    cs_flow_if.master bus
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        CMD_RX    = 4'd1,
        CMD_PARSE = 4'd2,
        CONF      = 4'd3,
        WAIT      = 4'd4,
        READ      = 4'd5,
        FIFO      = 4'd6,
        MAC       = 4'd7,
        TX        = 4'd8,
        ERR       = 4'd9
    } st_t;

    st_t              st_q, st_d, nxt;
    logic [15:0]      tmr_q, tmr_d;
    logic             pend_q, pend_d;
    logic [OVR_W-1:0] ovr_q;
    logic [6:0]       fs_q;
    logic             fdrx_q, err_q;
    logic             fd_cur, gated, stage, tmo, busy;

    always_comb begin
        nxt    = st_q;
        fd_cur = 1'b0;
        gated  = 1'b0;
        stage  = 1'b1;
        unique case (st_q)
            CMD_RX: begin
                nxt    = CMD_PARSE;
                fd_cur = bus.fd_mac2fifoc;
                gated  = bus.fifoc_full;
            end
            CMD_PARSE: begin
                nxt    = CONF;
                fd_cur = bus.fd_fifoc2cs;
            end
            CONF: begin
                nxt    = WAIT;
                fd_cur = bus.fd_adc_conf;
            end
            READ: begin
                nxt    = FIFO;
                fd_cur = bus.fd_adc_read;
            end
            FIFO: begin
                nxt    = MAC;
                fd_cur = bus.fd_adc_fifo;
                gated  = bus.fifod_full;
            end
            MAC: begin
                nxt    = TX;
                fd_cur = bus.fd_fifod2mac;
            end
            TX: begin
                nxt    = WAIT;
                fd_cur = bus.fd_udp_tx;
            end
            default: stage = 1'b0;
        endcase
    end

    assign tmo  = stage && !gated && (tmr_q == TIMEOUT - 16'd1);
    assign busy = (st_q >= READ) && (st_q <= TX);

    always_comb begin
        st_d   = st_q;
        pend_d = pend_q;
        tmr_d  = tmr_q;
        if (stage) begin
            if (fd_cur)
                st_d = nxt;
            else if (tmo)
                st_d = ERR;
        end else begin
            unique case (st_q)
                IDLE: if (bus.fs_udp_rx) st_d = CMD_RX;
                WAIT: begin
                    // a new command outranks a same-cycle sample tick
                    if (bus.fs_udp_rx || pend_q)
                        st_d = CMD_RX;
                    else if (bus.fs_adc)
                        st_d = READ;
                end
                default: st_d = IDLE;
            endcase
        end
        if ((st_d == CMD_RX && st_q != CMD_RX) || st_q == ERR)
            pend_d = 1'b0;
        else if (bus.fs_udp_rx && st_q != IDLE && st_q != WAIT)
            pend_d = 1'b1;
        if (st_d != st_q)
            tmr_d = 16'd0;
        else if (stage && !gated)
            tmr_d = tmr_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q   <= IDLE;
            tmr_q  <= 16'd0;
            pend_q <= 1'b0;
            ovr_q  <= '0;
            fs_q   <= '0;
            fdrx_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            tmr_q  <= tmr_d;
            pend_q <= pend_d;
            if (busy && bus.fs_adc && ovr_q != '1)
                ovr_q <= ovr_q + OVR_W'(1);
            fdrx_q  <= (st_d == CMD_RX) && (st_q != CMD_RX);
            err_q   <= (st_d == ERR);
            fs_q[0] <= (st_d == CMD_RX) && !bus.fifoc_full;
            fs_q[1] <= (st_d == CMD_PARSE);
            fs_q[2] <= (st_d == CONF);
            fs_q[3] <= (st_d == READ);
            fs_q[4] <= (st_d == FIFO) && !bus.fifod_full;
            fs_q[5] <= (st_d == MAC);
            fs_q[6] <= (st_d == TX);
        end
    end

    assign bus.fs_mac2fifoc = fs_q[0];
    assign bus.fs_fifoc2cs  = fs_q[1];
    assign bus.fs_adc_conf  = fs_q[2];
    assign bus.fs_adc_read  = fs_q[3];
    assign bus.fs_adc_fifo  = fs_q[4];
    assign bus.fs_fifod2mac = fs_q[5];
    assign bus.fs_udp_tx    = fs_q[6];
    assign bus.fd_udp_rx    = fdrx_q;
    assign bus.err          = err_q;
    assign bus.state        = st_q;
    assign bus.ovr_cnt      = ovr_q;

endmodule
